// File: rtl/csr_unit_if.sv
// -----------------------------------------------------------------------------
// csr_unit_if
//
// Execute-stage side of the CSR unit. It carries the CSR instruction fields,
// the pipeline qualifiers and the results returned by the unit.
//
//   master : pipeline / testbench side. Drives the request, sees the results.
//   slave  : csr_unit side.
//
// Signals
//   stall        pipeline freeze; blocks commits and instret counting
//   csr_en       a valid CSR instruction is in X this cycle
//   csr_op       01 RW, 10 RS, 11 RC, 00 read only
//   csr_addr     12-bit CSR address
//   csr_wdata    rs1 value or zero-extended zimm
//   csr_src_zero rs1 is x0 or zimm is 0 (removes write intent of RS/RC)
//   retire       one instruction retires this cycle
//   csr_rdata    old value of the addressed CSR (combinational)
//   csr_illegal  illegal access (combinational, qualified by csr_en)
//   csr_tohost   registered tohost value
//   tohost_valid one-cycle pulse after a tohost commit
// -----------------------------------------------------------------------------
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            csr_en;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_src_zero;
  logic            retire;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic [XLEN-1:0] csr_tohost;
  logic            tohost_valid;

  modport master (
    output stall, csr_en, csr_op, csr_addr, csr_wdata, csr_src_zero, retire,
    input  csr_rdata, csr_illegal, csr_tohost, tohost_valid
  );

  modport slave (
    input  stall, csr_en, csr_op, csr_addr, csr_wdata, csr_src_zero, retire,
    output csr_rdata, csr_illegal, csr_tohost, tohost_valid
  );
endinterface

// File: rtl/csr_unit.sv
// -----------------------------------------------------------------------------
// csr_unit
//
// Decoded control/status register space for the execute stage. Holds tohost,
// a bank of scratch CSRs and, optionally, 64-bit cycle/instret counters.
// Supports the Zicsr RW/RS/RC operations. Reads are combinational and always
// return the pre-write value; writes commit on the clock edge unless the
// pipeline is stalled.
//
// Address map
//   0x51E                     tohost  (RW)
//   0x7C0 .. 0x7C0+NS-1       scratch (RW)
//   0xC00 / 0xC02             cycle / instret, low XLEN bits   (read only)
//   0xC80 / 0xC82             cycle / instret, upper bits       (read only)
//
// Build option
//   CSR_COUNTERS_EN  when defined, the cycle/instret counters exist and their
//                    four addresses are readable. When undefined the counters
//                    are absent, those addresses are illegal and read 0, and
//                    retire is ignored.
//
// Ports
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    csr_unit_if slave modport (request in, rdata/illegal/tohost out)
//
// Parameters
//   XLEN         data width (32)
//   CNT_WIDTH    counter width, XLEN+1 .. 2*XLEN (64)
//   NUM_SCRATCH  number of scratch CSRs, 1..16 (4)
// -----------------------------------------------------------------------------
module csr_unit #(
  parameter int XLEN        = 32,
  parameter int CNT_WIDTH   = 64,
  parameter int NUM_SCRATCH = 4
) (
  input  logic       clk,
  input  logic       reset,
  csr_unit_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [11:0] ADDR_TOHOST   = 12'h51E;
  localparam logic [7:0]  SCRATCH_PAGE  = 8'h7C;    // 0x7C0 .. 0x7CF
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // ---------------------------------------------------------------------------
  // Request aliases
  // ---------------------------------------------------------------------------
  logic [11:0]     addr;
  logic [1:0]      op;
  logic [XLEN-1:0] wdata;

  assign addr  = bus.csr_addr;
  assign op    = bus.csr_op;
  assign wdata = bus.csr_wdata;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] tohost_q;
  logic            tohost_valid_q;

  // Read view of the scratch bank, padded to the full 16-entry page so that
  // addr[3:0] can index it directly; padding entries read as zero.
  logic [15:0][XLEN-1:0] scratch_rd;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic hit_tohost;
  logic hit_scratch;
  logic counter_mapped;
  logic mapped;

  assign hit_tohost  = (addr == ADDR_TOHOST);
  assign hit_scratch = (addr[11:4] == SCRATCH_PAGE) &&
                       ({1'b0, addr[3:0]} < 5'(NUM_SCRATCH));

`ifdef CSR_COUNTERS_EN
  assign counter_mapped = (addr == ADDR_CYCLE)  || (addr == ADDR_INSTRET) ||
                          (addr == ADDR_CYCLEH) || (addr == ADDR_INSTRETH);
`else
  assign counter_mapped = 1'b0;
`endif

  assign mapped = hit_tohost || hit_scratch || counter_mapped;

  // ---------------------------------------------------------------------------
  // Write intent and legality
  // ---------------------------------------------------------------------------
  // RS/RC with a zero source are pure reads: they must not trap on read-only
  // CSRs and must not disturb state.
  logic write_intent;
  logic illegal;
  logic commit;

  always_comb begin
    case (op)
      OP_RW:   write_intent = 1'b1;
      OP_RS,
      OP_RC:   write_intent = !bus.csr_src_zero;
      default: write_intent = 1'b0;
    endcase
  end

  // addr[11:10] == 2'b11 is the architecturally read-only quadrant.
  assign illegal = bus.csr_en &&
                   (!mapped || (write_intent && (addr[11:10] == 2'b11)));

  assign commit = bus.csr_en && write_intent && !illegal && !bus.stall;

  // ---------------------------------------------------------------------------
  // Counters (optional)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] counter_rdata;

`ifdef CSR_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] cycle_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [CNT_WIDTH-1:0] instret_d;

  // cycle keeps running through stalls; instret only counts retirements that
  // actually leave the pipeline. Both wrap naturally at 2^CNT_WIDTH.
  assign cycle_d   = cycle_q + CNT_WIDTH'(1);
  assign instret_d = (bus.retire && !bus.stall) ? instret_q + CNT_WIDTH'(1)
                                                : instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    counter_rdata = '0;
    case (addr)
      ADDR_CYCLE:    counter_rdata = cycle_q[XLEN-1:0];
      ADDR_INSTRET:  counter_rdata = instret_q[XLEN-1:0];
      ADDR_CYCLEH:   counter_rdata = XLEN'(cycle_q[CNT_WIDTH-1:XLEN]);
      ADDR_INSTRETH: counter_rdata = XLEN'(instret_q[CNT_WIDTH-1:XLEN]);
      default:       counter_rdata = '0;
    endcase
  end
`else
  // Without counters there is nothing for retire to drive.
  logic unused_retire;
  assign unused_retire = bus.retire;
  assign counter_rdata = '0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux: always the value held before any write in this cycle
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] old_value;

  always_comb begin
    old_value = '0;
    if (hit_tohost) begin
      old_value = tohost_q;
    end else if (hit_scratch) begin
      old_value = scratch_rd[addr[3:0]];
    end else if (counter_mapped) begin
      old_value = counter_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // New value for RW / RS / RC
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] new_value;

  always_comb begin
    case (op)
      OP_RW:   new_value = wdata;
      OP_RS:   new_value = old_value | wdata;
      OP_RC:   new_value = old_value & ~wdata;
      default: new_value = old_value;
    endcase
  end

  // ---------------------------------------------------------------------------
  // tohost
  // ---------------------------------------------------------------------------
  // The valid pulse follows every commit, even one that rewrites the same
  // value, so the host sees each store.
  always_ff @(posedge clk) begin
    if (reset) begin
      tohost_q       <= '0;
      tohost_valid_q <= 1'b0;
    end else begin
      tohost_valid_q <= commit && hit_tohost;
      if (commit && hit_tohost) begin
        tohost_q <= new_value;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scratch bank
  // ---------------------------------------------------------------------------
  // Kept as discrete registers: every entry must be readable combinationally
  // in the same cycle, which rules out a synchronous-read RAM.
  for (genvar gi = 0; gi < 16; gi++) begin : g_scratch
    if (gi < NUM_SCRATCH) begin : g_reg
      logic [XLEN-1:0] entry_q;
      logic            entry_we;

      assign entry_we = commit && hit_scratch && (addr[3:0] == 4'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          entry_q <= '0;
        end else if (entry_we) begin
          entry_q <= new_value;
        end
      end

      assign scratch_rd[gi] = entry_q;
    end else begin : g_pad
      assign scratch_rd[gi] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.csr_rdata    = old_value;
  assign bus.csr_illegal  = illegal;
  assign bus.csr_tohost   = tohost_q;
  assign bus.tohost_valid = tohost_valid_q;

endmodule
